// File: rtl/sys_array_ctrl.sv
// rtl/sys_array_ctrl.sv - weight-stationary systolic array sequencer
//
// Runs one job per accepted start: a weight-load phase that shifts ARRAY_H
// weight rows into the grid bottom-row-first, then a feed/drain phase that
// streams num_vecs skewed input vectors and raises the per-column and
// deskewed result strobes. Drives control and addresses only.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   start, num_vecs       job request and vector count, sampled in IDLE only
//   abort                 synchronous abort back to IDLE
//   busy, done, error     job status; done and error are one-cycle pulses
//   param_load            weight shift enable to every cell
//   param_rd_en           weight buffer read strobe
//   param_row_addr        weight row presented to the top row
//   input_rd_en           input buffer read strobe
//   input_addr            input vector index
//   row_valid             per-row skewed input enable
//   col_valid             per-column output valid at the bottom of the grid
//   out_wr_en, out_addr   deskewed result write strobe and vector index

module sys_array_ctrl #(
  parameter int ARRAY_H  = 4,
  parameter int ARRAY_W  = 4,
  parameter int MAX_VECS = 256,
  parameter int VEC_W    = $clog2(MAX_VECS + 1),
  parameter int T_W      = $clog2(MAX_VECS + ARRAY_H + ARRAY_W + 1),
  parameter int RA_W     = (ARRAY_H > 1) ? $clog2(ARRAY_H) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [VEC_W-1:0]   num_vecs,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               param_load,
  output logic               param_rd_en,
  output logic [RA_W-1:0]    param_row_addr,
  output logic               input_rd_en,
  output logic [VEC_W-1:0]   input_addr,
  output logic [ARRAY_H-1:0] row_valid,
  output logic [ARRAY_W-1:0] col_valid,
  output logic               out_wr_en,
  output logic [VEC_W-1:0]   out_addr
);

  // Comparisons are done one bit wider than the timer so that bound + N
  // never wraps, even for the largest job.
  localparam int CW = T_W + 1;

  localparam logic [VEC_W-1:0] MAX_N     = VEC_W'(MAX_VECS);
  localparam logic [T_W-1:0]   LOAD_LAST = T_W'(ARRAY_H - 1);
  localparam logic [CW-1:0]    DRAIN_LEN = CW'(ARRAY_W + ARRAY_H - 2);
  localparam logic [CW-1:0]    OUT_T0    = CW'(ARRAY_W - 1 + ARRAY_H);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_W,
    S_FEED,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [T_W-1:0]   r_timer;
  logic [VEC_W-1:0] r_num;

  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic               r_param_load;
  logic               r_param_rd_en;
  logic [RA_W-1:0]    r_param_row_addr;
  logic               r_input_rd_en;
  logic [VEC_W-1:0]   r_input_addr;
  logic [ARRAY_H-1:0] r_row_valid;
  logic [ARRAY_W-1:0] r_col_valid;
  logic               r_out_wr_en;
  logic [VEC_W-1:0]   r_out_addr;

  state_t           w_nstate;
  logic [T_W-1:0]   w_ntimer;
  logic [VEC_W-1:0] w_nnum;
  logic             w_nerror;
  logic             w_num_ok;
  logic [CW-1:0]    w_feed_last;

  logic [CW-1:0]    w_t;
  logic [CW-1:0]    w_n;

  logic               w_busy;
  logic               w_done;
  logic               w_param_load;
  logic [RA_W-1:0]    w_param_row_addr;
  logic               w_input_rd_en;
  logic [VEC_W-1:0]   w_input_addr;
  logic [ARRAY_H-1:0] w_row_valid;
  logic [ARRAY_W-1:0] w_col_valid;
  logic               w_out_wr_en;
  logic [VEC_W-1:0]   w_out_addr;

  assign w_num_ok    = (num_vecs != '0) && (num_vecs <= MAX_N);
  assign w_feed_last = {{(CW-VEC_W){1'b0}}, r_num} + DRAIN_LEN;

  // Next-state logic. abort wins over everything, including a start in IDLE.
  always_comb begin
    w_nstate = r_state;
    w_ntimer = r_timer;
    w_nnum   = r_num;
    w_nerror = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ntimer = '0;
        if (!abort && start) begin
          if (w_num_ok) begin
            w_nstate = S_LOAD_W;
            w_nnum   = num_vecs;
          end else begin
            w_nerror = 1'b1;
          end
        end
      end
      S_LOAD_W: begin
        if (abort) begin
          w_nstate = S_IDLE;
          w_ntimer = '0;
        end else if (r_timer == LOAD_LAST) begin
          w_nstate = S_FEED;
          w_ntimer = '0;
        end else begin
          w_ntimer = r_timer + T_W'(1);
        end
      end
      S_FEED: begin
        if (abort) begin
          w_nstate = S_IDLE;
          w_ntimer = '0;
        end else if ({1'b0, r_timer} == w_feed_last) begin
          w_nstate = S_DONE;
          w_ntimer = '0;
        end else begin
          w_ntimer = r_timer + T_W'(1);
        end
      end
      default: begin
        w_nstate = S_IDLE;
        w_ntimer = '0;
      end
    endcase
  end

  assign w_t = {1'b0, w_ntimer};
  assign w_n = {{(CW-VEC_W){1'b0}}, w_nnum};

  // Output decode from the upcoming state/timer so that the registered
  // outputs line up with the cycle that state is active.
  always_comb begin
    w_busy           = (w_nstate != S_IDLE);
    w_done           = 1'b0;
    w_param_load     = 1'b0;
    w_param_row_addr = '0;
    w_input_rd_en    = 1'b0;
    w_input_addr     = '0;
    w_row_valid      = '0;
    w_col_valid      = '0;
    w_out_wr_en      = 1'b0;
    w_out_addr       = '0;
    case (w_nstate)
      S_LOAD_W: begin
        w_param_load     = 1'b1;
        // Bottom row first: it is pushed down by the later rows.
        w_param_row_addr = RA_W'(ARRAY_H - 1) - w_ntimer[RA_W-1:0];
      end
      S_FEED: begin
        w_input_rd_en = (w_t < w_n);
        if (w_input_rd_en) begin
          w_input_addr = w_ntimer[VEC_W-1:0];
        end
        // Row r sees vector v at t = v + r.
        for (int r = 0; r < ARRAY_H; r++) begin
          w_row_valid[r] = (w_t >= CW'(r)) && (w_t < CW'(r) + w_n);
        end
        // Column c result for vector v reaches the bottom at t = v + c + ARRAY_H.
        for (int c = 0; c < ARRAY_W; c++) begin
          w_col_valid[c] = (w_t >= CW'(c + ARRAY_H)) &&
                           (w_t < CW'(c + ARRAY_H) + w_n);
        end
        // Whole vector is complete once the last column has produced it.
        w_out_wr_en = (w_t >= OUT_T0) && (w_t < OUT_T0 + w_n);
        if (w_out_wr_en) begin
          w_out_addr = VEC_W'(w_t - OUT_T0);
        end
      end
      S_DONE: begin
        w_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= S_IDLE;
      r_timer          <= '0;
      r_num            <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_error          <= 1'b0;
      r_param_load     <= 1'b0;
      r_param_rd_en    <= 1'b0;
      r_param_row_addr <= '0;
      r_input_rd_en    <= 1'b0;
      r_input_addr     <= '0;
      r_row_valid      <= '0;
      r_col_valid      <= '0;
      r_out_wr_en      <= 1'b0;
      r_out_addr       <= '0;
    end else begin
      r_state          <= w_nstate;
      r_timer          <= w_ntimer;
      r_num            <= w_nnum;
      r_busy           <= w_busy;
      r_done           <= w_done;
      r_error          <= w_nerror;
      r_param_load     <= w_param_load;
      r_param_rd_en    <= w_param_load;
      r_param_row_addr <= w_param_row_addr;
      r_input_rd_en    <= w_input_rd_en;
      r_input_addr     <= w_input_addr;
      r_row_valid      <= w_row_valid;
      r_col_valid      <= w_col_valid;
      r_out_wr_en      <= w_out_wr_en;
      r_out_addr       <= w_out_addr;
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign error          = r_error;
  assign param_load     = r_param_load;
  assign param_rd_en    = r_param_rd_en;
  assign param_row_addr = r_param_row_addr;
  assign input_rd_en    = r_input_rd_en;
  assign input_addr     = r_input_addr;
  assign row_valid      = r_row_valid;
  assign col_valid      = r_col_valid;
  assign out_wr_en      = r_out_wr_en;
  assign out_addr       = r_out_addr;

endmodule

// File: tb/tb_sys_array_ctrl.sv
// tb/tb_sys_array_ctrl.sv - directed self-checking bench for sys_array_ctrl

module tb_sys_array_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic [8:0] num_vecs;
  logic       busy, done, error, param_load, param_rd_en;
  logic [1:0] param_row_addr;
  logic       input_rd_en;
  logic [8:0] input_addr;
  logic [3:0] row_valid;
  logic [3:0] col_valid;
  logic       out_wr_en;
  logic [8:0] out_addr;

  int n_checks = 0;
  int n_fail   = 0;

  sys_array_ctrl #(
    .ARRAY_H(4),
    .ARRAY_W(4),
    .MAX_VECS(256)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .abort(abort),
    .num_vecs(num_vecs),
    .busy(busy),
    .done(done),
    .error(error),
    .param_load(param_load),
    .param_rd_en(param_rd_en),
    .param_row_addr(param_row_addr),
    .input_rd_en(input_rd_en),
    .input_addr(input_addr),
    .row_valid(row_valid),
    .col_valid(col_valid),
    .out_wr_en(out_wr_en),
    .out_addr(out_addr)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic b, input logic d, input logic e,
                                       input logic pl, input logic prd, input logic [1:0] ra,
                                       input logic ird, input logic [8:0] ia,
                                       input logic [3:0] rv, input logic [3:0] cv,
                                       input logic ow, input logic [8:0] oa);
    return {29'd0, b, d, e, pl, prd, ra, ird, ia, rv, cv, ow, oa};
  endfunction

  function automatic logic [63:0] obs_raw();
    return pack(busy, done, error, param_load, param_rd_en, param_row_addr,
                input_rd_en, input_addr, row_valid, col_valid, out_wr_en, out_addr);
  endfunction

  // Small weight-stationary grid model driven by the controller's strobes.
  int wbuf  [4][4];
  int invec [4][4];
  int wgt   [4][4];
  int av    [4][4];
  int ps    [4][4];
  int hist  [3][4];
  int cbuf  [4][8];
  int cwi   [4];
  int res   [4][4];

  function automatic int rd_elem(input int r);
    if (!input_rd_en) return 0;
    if (input_addr < 9'd4) return invec[int'(input_addr)][r];
    return 1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          wgt[r][c] <= 0;
          av[r][c]  <= 0;
          ps[r][c]  <= 0;
        end
      for (int i = 0; i < 3; i++)
        for (int k = 0; k < 4; k++) hist[i][k] <= 0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        hist[0][k] <= rd_elem(k);
        hist[1][k] <= hist[0][k];
        hist[2][k] <= hist[1][k];
      end
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          int a_in;
          int p_up;
          if (c == 0)
            a_in = !row_valid[r] ? 0 : ((r == 0) ? rd_elem(0) : hist[r-1][r]);
          else
            a_in = av[r][c-1];
          p_up = (r == 0) ? 0 : ps[r-1][c];
          av[r][c] <= a_in;
          ps[r][c] <= p_up + a_in * wgt[r][c];
        end
      end
      if (param_load) begin
        for (int c = 0; c < 4; c++) begin
          wgt[0][c] <= wbuf[int'(param_row_addr)][c];
          for (int r = 1; r < 4; r++) wgt[r][c] <= wgt[r-1][c];
        end
      end
    end
  end

  // Runs one job: start at the current negedge, then compares every cycle.
  // c counts cycles from the first LOAD_W cycle; st_c/ab_c pulse start/abort.
  task automatic run_job(input string name, input int n, input int st_c, input int ab_c,
                         output int n_pl, output int n_ow, output int last_ow);
    int total;
    n_pl = 0;
    n_ow = 0;
    last_ow = -1;
    for (int c = 0; c < 4; c++) cwi[c] = 0;
    total = 4 + n + 7 + 1 + 2;
    start = 1'b1;
    num_vecs = 9'(n);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < total; c++) begin
      logic b, d, pl, ird, ow;
      logic [1:0] ra;
      logic [8:0] ia, oa;
      logic [3:0] rv, cv;
      int t;
      b = 0; d = 0; pl = 0; ird = 0; ow = 0; ra = 0; ia = 0; oa = 0; rv = 0; cv = 0;
      if (ab_c >= 0 && c > ab_c) begin
      end else if (c < 4) begin
        b = 1; pl = 1; ra = 2'(3 - c);
      end else if (c < 4 + n + 7) begin
        b = 1;
        t = c - 4;
        ird = (t < n);
        ia = ird ? 9'(t) : 9'd0;
        for (int r = 0; r < 4; r++) rv[r] = (t >= r) && (t < r + n);
        for (int k = 0; k < 4; k++) cv[k] = (t >= k + 4) && (t < k + 4 + n);
        ow = (t >= 7) && (t < 7 + n);
        oa = ow ? 9'(t - 7) : 9'd0;
      end else if (c == 4 + n + 7) begin
        b = 1; d = 1;
      end
      check_val($sformatf("%s_c%0d", name, c),
                pack(busy, done, error, param_load, param_rd_en, pl ? param_row_addr : 2'd0,
                     input_rd_en, ird ? input_addr : 9'd0, row_valid, col_valid,
                     out_wr_en, ow ? out_addr : 9'd0),
                pack(b, d, 1'b0, pl, pl, ra, ird, ia, rv, cv, ow, oa));
      if (param_load) n_pl++;
      for (int k = 0; k < 4; k++)
        if (col_valid[k]) begin
          if (cwi[k] < 8) cbuf[k][cwi[k]] = ps[3][k];
          cwi[k]++;
        end
      if (out_wr_en) begin
        n_ow++;
        last_ow = c;
        if (out_addr < 9'd4)
          for (int k = 0; k < 4; k++) res[int'(out_addr)][k] = cbuf[k][int'(out_addr)];
      end
      start = (c == st_c);
      abort = (c == ab_c);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int npl, now, lastc;
    int exp_sum [3];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        wbuf[r][c] = 5;
        invec[r][c] = 0;
        res[r][c] = -1;
      end
    for (int k = 0; k < 4; k++) begin
      invec[0][k] = 1;
      invec[1][k] = 5;
      invec[2][k] = (k % 2 == 0) ? 1 : 5;
    end
    exp_sum[0] = 20;
    exp_sum[1] = 100;
    exp_sum[2] = 60;

    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    num_vecs = 9'd0;
    repeat (3) @(negedge clk);
    check_val("reset_state", obs_raw(), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Weight load, skew, valids, done, array sums.
    run_job("job3", 3, -1, -1, npl, now, lastc);
    check_val("job3_param_load_cycles", 64'(npl), 64'd4);
    check_val("job3_out_wr_cycles", 64'(now), 64'd3);
    check_val("job3_last_wr_t", 64'(lastc - 4), 64'd9);
    for (int v = 0; v < 3; v++)
      for (int c = 0; c < 4; c++)
        check_val($sformatf("sum_v%0d_c%0d", v, c), 64'(res[v][c]), 64'(exp_sum[v]));

    // Rejected starts.
    start = 1'b1;
    num_vecs = 9'd0;
    @(negedge clk);
    start = 1'b0;
    check_val("err_zero_pulse", {62'd0, error, busy}, 64'd2);
    @(negedge clk);
    check_val("err_zero_clear", {62'd0, error, busy}, 64'd0);
    start = 1'b1;
    num_vecs = 9'd257;
    @(negedge clk);
    start = 1'b0;
    check_val("err_257_pulse", {62'd0, error, busy}, 64'd2);
    @(negedge clk);
    check_val("err_257_clear", {62'd0, error, busy}, 64'd0);
    // Abort beats start in IDLE: no error, no job.
    start = 1'b1;
    abort = 1'b1;
    num_vecs = 9'd0;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_val("abort_prio_idle", {62'd0, error, busy}, 64'd0);
    @(negedge clk);

    // Start while busy is ignored.
    run_job("busy_start", 3, 5, -1, npl, now, lastc);

    // Abort at FEED t=5, then a one-vector job.
    run_job("abort", 3, -1, 9, npl, now, lastc);
    check_val("abort_out_wr_cycles", 64'(now), 64'd0);
    run_job("job1", 1, -1, -1, npl, now, lastc);
    check_val("job1_out_wr_cycles", 64'(now), 64'd1);
    check_val("job1_wr_t", 64'(lastc - 4), 64'd7);

    // Asynchronous reset mid LOAD_W.
    start = 1'b1;
    num_vecs = 9'd3;
    @(negedge clk);
    start = 1'b0;
    check_val("pre_reset_load", {63'd0, param_load}, 64'd1);
    #2 reset_n = 1'b0;
    #1 check_val("async_reset", obs_raw(), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("post_reset_idle", obs_raw(), 64'd0);

    // Largest job.
    run_job("job256", 256, -1, -1, npl, now, lastc);
    check_val("job256_out_wr_cycles", 64'(now), 64'd256);
    check_val("job256_last_wr_t", 64'(lastc - 4), 64'd262);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_array_ctrl.md
Name: sys_array_ctrl

Overview:
- Sequencer for a weight-stationary ARRAY_H x ARRAY_W grid of sys_array_cell instances.
- On start it runs two phases:
  - Weight load: pulses param_load for ARRAY_H cycles and addresses the weight buffer so rows shift in bottom-first.
  - Feed/drain: streams num_vecs input vectors with per-row diagonal skew, then generates per-column output-valid strobes and a deskewed result write strobe.
- Sits between the weight, input and result buffers and the array. It drives control and addresses only; no data passes through it.

Parameters:
- ARRAY_H, 4, number of array rows (input vector length).
- ARRAY_W, 4, number of array columns (output vector length).
- MAX_VECS, 256, maximum vectors per job.
- VEC_W, $clog2(MAX_VECS+1), width of num_vecs and vector addresses.
- T_W, $clog2(MAX_VECS+ARRAY_H+ARRAY_W+1), width of the phase timer.

Ports:
- clk, input, 1, clock, rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- start, input, 1, job request; sampled only in IDLE.
- abort, input, 1, synchronous abort; returns to IDLE.
- num_vecs, input, VEC_W, vectors in the job; sampled with start.
- busy, output, 1, high in LOAD_W, FEED and DONE.
- done, output, 1, one-cycle completion pulse.
- error, output, 1, one-cycle pulse when start is rejected.
- param_load, output, 1, to all cells' param_load.
- param_rd_en, output, 1, weight buffer read strobe.
- param_row_addr, output, $clog2(ARRAY_H), weight row to present on the param_data of the top row.
- input_rd_en, output, 1, input buffer read strobe.
- input_addr, output, VEC_W, input vector index.
- row_valid, output, ARRAY_H, per-row skew enable; bit r gates input_data into row r.
- col_valid, output, ARRAY_W, per-column output valid at the bottom of column c.
- out_wr_en, output, 1, result buffer write strobe (deskewed vector complete).
- out_addr, output, VEC_W, result vector index.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; timer and all counters cleared.
  - Every output is 0: busy, done, error, param_load, param_rd_en, param_row_addr, input_rd_en, input_addr, row_valid, col_valid, out_wr_en, out_addr.
  - Reset mid-job aborts immediately; no done is generated.
- All outputs are registered (Moore). Buffers are zero-latency relative to the strobes.
- States and transitions: IDLE -> LOAD_W -> FEED -> DONE -> IDLE.
- IDLE:
  - start=1 and 1<=num_vecs<=MAX_VECS: latch num_vecs and go to LOAD_W.
  - start=1 and num_vecs==0 or num_vecs>MAX_VECS: error=1 for one cycle, stay IDLE.
- LOAD_W: exactly ARRAY_H cycles, k=0..ARRAY_H-1.
  - param_load=1 and param_rd_en=1.
  - param_row_addr = ARRAY_H-1-k (bottom row loaded first, pushed down by propagation).
  - After the last cycle go to FEED with timer t=0.
- FEED: timer t counts from 0. With N = latched num_vecs:
  - input_rd_en=1 and input_addr=t for t in [0, N-1].
  - row_valid[r]=1 for t in [r, r+N-1]; row r receives vector v at t=v+r.
  - col_valid[c]=1 for t in [c+ARRAY_H, c+ARRAY_H+N-1]. Column c output for vector v appears at t=v+c+ARRAY_H: one cycle per cell, with data moving right and partial sums moving down.
  - out_wr_en=1 for t in [ARRAY_W-1+ARRAY_H, ARRAY_W-1+ARRAY_H+N-1], with out_addr = t-(ARRAY_W-1+ARRAY_H).
  - Leave FEED after t = N+ARRAY_W+ARRAY_H-2, then go to DONE.
- DONE: one cycle. done=1, busy=1, all strobes 0. Next state is IDLE.
- start outside IDLE is ignored: no error, no restart.
- abort=1 in any non-IDLE state:
  - Next cycle state=IDLE and all outputs are 0; no done.
  - If start and abort are both high in IDLE, abort has priority and the start is ignored.
- Timer and address arithmetic is unsigned with no wrap. N=MAX_VECS must complete correctly; T_W is sized for the maximum t.

Test Plan (ARRAY_H=ARRAY_W=4, MAX_VECS=256):
1. Weight load: reset, then start with num_vecs=3.
   - Required: param_load high for exactly 4 cycles, with param_row_addr 3,2,1,0.
   - Then FEED t=0: input_rd_en high at t=0..2, input_addr 0,1,2.
2. Skew and valids, same job:
   - row_valid[0] at t=0..2 and row_valid[3] at t=3..5.
   - col_valid[0] at t=4..6 and col_valid[3] at t=7..9.
   - out_wr_en at t=7..9 with out_addr 0,1,2.
   - done pulses one cycle after t=9; busy goes low the following cycle.
   - Bench check: a 4x4 model of cells with weights 5 and inputs 1, 5 gives column sums matching the collected out_data.
3. Error: start with num_vecs=0 -> error=1 for one cycle, busy stays 0. Then start with num_vecs=257 -> error pulse.
4. Start while busy: start at FEED t=1 -> no effect; the job completes exactly as in scenario 2.
5. Abort and reset:
   - abort at FEED t=5 -> next cycle all outputs 0, no done.
   - A new start with num_vecs=1 then completes: out_wr_en at t=7, done next cycle.
   - reset_n low mid-LOAD_W clears all outputs asynchronously, without waiting for a clock edge.
6. Boundary: num_vecs=256 -> out_wr_en high 256 consecutive cycles, out_addr 0..255; the last write is at t=262 and done follows.
